// File: rtl/ppu_sprite_eval_if.sv
// Bus bundle for the sprite evaluator: primary SPRAM read port and
// the renderer-side secondary OAM read port.
interface ppu_sprite_eval_if #(
   parameter int OAM_AW = 8,
   parameter int SAW    = 5
);
   logic [OAM_AW-1:0] spram_addr;
   logic [7:0]        spram_data;
   logic [SAW-1:0]    sec_rd_addr;
   logic [7:0]        sec_rd_data;

   modport master (
      output spram_addr,
      input  spram_data,
      input  sec_rd_addr,
      output sec_rd_data
   );

   modport slave (
      input  spram_addr,
      output spram_data,
      output sec_rd_addr,
      input  sec_rd_data
   );
endinterface

// File: rtl/ppu_sprite_eval.sv
// Per-scanline sprite evaluation: scans primary SPRAM and copies in-range
// sprites into a small secondary OAM for the renderer.
module ppu_sprite_eval #(
   parameter int NUM_SPRITES  = 64,
   parameter int MAX_PER_LINE = 8,
   parameter int OAM_AW       = 8,
   localparam int CW  = $clog2(MAX_PER_LINE) + 1,
   localparam int SAW = $clog2(MAX_PER_LINE) + 2,
   localparam int NW  = $clog2(NUM_SPRITES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [8:0]        scanline,
   input  logic              sprite_16,
   input  logic [OAM_AW-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic [CW-1:0]     sprite_count,
   output logic              overflow,
   output logic              sprite0_hit,
   ppu_sprite_eval_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_READ_Y, S_CHECK_Y, S_COPY, S_DONE
   } state_t;

   state_t state, state_next;

   logic [8:0]        scan_q;
   logic              s16_q;
   logic [OAM_AW-1:0] base_q;
   logic [NW-1:0]     n;
   logic [1:0]        cp;
   logic [SAW-1:0]    clr_idx;
   logic [7:0]        sec_oam [4*MAX_PER_LINE];

   logic              accept, n_inc, cnt_inc, set_ovf, set_s0;
   logic              sec_we;
   logic [SAW-1:0]    sec_waddr;
   logic [7:0]        sec_wdata;
   logic [OAM_AW-1:0] rd_off;
   logic [1:0]        cp_plus;
   logic [9:0]        diff;
   logic              in_range, last_sprite, full;
   logic [SAW-1:0]    slot_base;

   // Signed distance from the sprite's top row; the top bit flags "above".
   assign diff        = {1'b0, scan_q} - {2'b00, bus.spram_data};
   assign in_range    = !diff[9] && (diff[8:0] < (s16_q ? 9'd16 : 9'd8));
   assign last_sprite = (n == NW'(NUM_SPRITES - 1));
   assign full        = (sprite_count == CW'(MAX_PER_LINE));
   assign slot_base   = SAW'({sprite_count, 2'b00});
   assign cp_plus     = cp + 2'd1;
   assign rd_off      = (state == S_COPY) ? OAM_AW'(cp_plus) : '0;

   assign bus.spram_addr  = base_q + OAM_AW'({n, 2'b00}) + rd_off;
   assign bus.sec_rd_data = sec_oam[bus.sec_rd_addr];

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      n_inc      = 1'b0;
      cnt_inc    = 1'b0;
      set_ovf    = 1'b0;
      set_s0     = 1'b0;
      sec_we     = 1'b0;
      sec_waddr  = clr_idx;
      sec_wdata  = 8'hFF;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = S_CLEAR;
            end
         end
         S_CLEAR: begin
            sec_we = 1'b1;
            if (clr_idx == {SAW{1'b1}}) state_next = S_READ_Y;
         end
         S_READ_Y: state_next = S_CHECK_Y;
         S_CHECK_Y: begin
            if (!in_range) begin
               n_inc      = 1'b1;
               state_next = last_sprite ? S_DONE : S_READ_Y;
            end else if (!full) begin
               sec_we     = 1'b1;
               sec_waddr  = slot_base;
               sec_wdata  = bus.spram_data;
               set_s0     = (n == '0);
               state_next = S_COPY;
            end else begin
               set_ovf    = 1'b1;
               state_next = S_DONE;
            end
         end
         S_COPY: begin
            // Data for the read issued in the previous COPY cycle lands now.
            if (cp != 2'd0) begin
               sec_we    = 1'b1;
               sec_waddr = slot_base | SAW'(cp);
               sec_wdata = bus.spram_data;
            end
            if (cp == 2'd3) begin
               n_inc      = 1'b1;
               cnt_inc    = 1'b1;
               state_next = last_sprite ? S_DONE : S_READ_Y;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q       <= '0;
         s16_q        <= 1'b0;
         base_q       <= '0;
         n            <= '0;
         cp           <= '0;
         clr_idx      <= '0;
         sprite_count <= '0;
         overflow     <= 1'b0;
         sprite0_hit  <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= (state == S_DONE);
         if (state == S_DONE) busy <= 1'b0;
         if (accept) begin
            scan_q       <= scanline;
            s16_q        <= sprite_16;
            base_q       <= base_addr;
            n            <= '0;
            cp           <= '0;
            clr_idx      <= '0;
            sprite_count <= '0;
            overflow     <= 1'b0;
            sprite0_hit  <= 1'b0;
            busy         <= 1'b1;
         end
         if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;
         if (state == S_COPY)  cp <= cp + 2'd1;
         if (n_inc)   n <= n + 1'b1;
         if (cnt_inc) sprite_count <= sprite_count + 1'b1;
         if (set_ovf) overflow <= 1'b1;
         if (set_s0)  sprite0_hit <= 1'b1;
      end
   end

   // Secondary OAM deliberately has no reset; CLEAR initialises it per line.
   always_ff @(posedge clk) begin
      if (sec_we) sec_oam[sec_waddr] <= sec_wdata;
   end

endmodule

// File: tb/tb_ppu_sprite_eval.sv
// Directed self-checking bench for ppu_sprite_eval with a registered-read
// SPRAM model and hand-computed expectations.
module tb_ppu_sprite_eval;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [8:0] scanline;
   logic       sprite_16;
   logic [7:0] base_addr;
   logic       busy, done, overflow, sprite0_hit;
   logic [3:0] sprite_count;
   logic [7:0] spram [256];
   int         checks   = 0;
   int         failures = 0;
   int         lat;

   ppu_sprite_eval_if #(.OAM_AW(8), .SAW(5)) bus ();

   ppu_sprite_eval #(.NUM_SPRITES(64), .MAX_PER_LINE(8), .OAM_AW(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .scanline     (scanline),
      .sprite_16    (sprite_16),
      .base_addr    (base_addr),
      .busy         (busy),
      .done         (done),
      .sprite_count (sprite_count),
      .overflow     (overflow),
      .sprite0_hit  (sprite0_hit),
      .bus          (bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.spram_data <= spram[bus.spram_addr];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic checkSec(input string tag, input int addr, input logic [7:0] exp);
      bus.sec_rd_addr = 5'(addr);
      #1;
      checkOutput($sformatf("%s[%0d]", tag, addr), {24'd0, bus.sec_rd_data}, {24'd0, exp});
   endtask

   task automatic setAllOff();
      for (int i = 0; i < 256; i++) spram[i] = (i % 4 == 0) ? 8'hFF : 8'h00;
   endtask

   task automatic setSprite(input int addr, input logic [7:0] y, input logic [7:0] t,
                            input logic [7:0] a, input logic [7:0] x);
      spram[addr]     = y;
      spram[addr + 1] = t;
      spram[addr + 2] = a;
      spram[addr + 3] = x;
   endtask

   // Counts rising edges from the one that samples start until done is seen.
   task automatic waitDone(output int edges);
      edges = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         edges++;
      end while (!done && edges < 3000);
      checkOutput("done_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic applyStimulus(input logic [8:0] sl, input logic s16, input logic [7:0] base,
                                output int edges);
      @(negedge clk);
      scanline  = sl;
      sprite_16 = s16;
      base_addr = base;
      start     = 1'b1;
      waitDone(edges);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; scanline = '0; sprite_16 = 1'b0; base_addr = '0;
      bus.sec_rd_addr = '0;
      setAllOff();
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_count", {28'd0, sprite_count}, 32'd0);
      checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
      checkOutput("rst_s0", {31'd0, sprite0_hit}, 32'd0);
      checkOutput("rst_addr", {24'd0, bus.spram_addr}, 32'd0);
      rst = 1'b0;

      $display("[TB] test 1: nothing in range");
      applyStimulus(9'd10, 1'b0, 8'h00, lat);
      checkOutput("t1_latency", lat, 32'd162);
      checkOutput("t1_count", {28'd0, sprite_count}, 32'd0);
      checkOutput("t1_ovf", {31'd0, overflow}, 32'd0);
      checkOutput("t1_s0", {31'd0, sprite0_hit}, 32'd0);
      for (int i = 0; i < 32; i++) checkSec("t1_sec", i, 8'hFF);
      @(negedge clk);
      checkOutput("t1_done_pulse", {31'd0, done}, 32'd0);
      checkOutput("t1_busy_low", {31'd0, busy}, 32'd0);

      $display("[TB] test 2: sprite 0 in range");
      setSprite(0, 8'd5, 8'h12, 8'h01, 8'h40);
      applyStimulus(9'd12, 1'b0, 8'h00, lat);
      checkOutput("t2_latency", lat, 32'd166);
      checkOutput("t2_count", {28'd0, sprite_count}, 32'd1);
      checkOutput("t2_s0", {31'd0, sprite0_hit}, 32'd1);
      checkSec("t2_sec", 0, 8'h05);
      checkSec("t2_sec", 1, 8'h12);
      checkSec("t2_sec", 2, 8'h01);
      checkSec("t2_sec", 3, 8'h40);
      for (int i = 4; i < 32; i++) checkSec("t2_sec", i, 8'hFF);

      $display("[TB] test 3: height boundaries");
      applyStimulus(9'd13, 1'b0, 8'h00, lat);
      checkOutput("t3a_count", {28'd0, sprite_count}, 32'd0);
      checkOutput("t3a_s0", {31'd0, sprite0_hit}, 32'd0);
      applyStimulus(9'd13, 1'b1, 8'h00, lat);
      checkOutput("t3b_count", {28'd0, sprite_count}, 32'd1);
      applyStimulus(9'd21, 1'b1, 8'h00, lat);
      checkOutput("t3c_count", {28'd0, sprite_count}, 32'd0);

      $display("[TB] test 4: overflow");
      setAllOff();
      for (int i = 0; i < 10; i++)
         setSprite(4 * i, 8'd100, 8'(i), 8'(8'h20 + i), 8'(8'h80 + i));
      applyStimulus(9'd104, 1'b0, 8'h00, lat);
      checkOutput("t4_count", {28'd0, sprite_count}, 32'd8);
      checkOutput("t4_ovf", {31'd0, overflow}, 32'd1);
      checkOutput("t4_s0", {31'd0, sprite0_hit}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         checkSec("t4_sec", 4 * i, 8'd100);
         checkSec("t4_sec", 4 * i + 1, 8'(i));
         checkSec("t4_sec", 4 * i + 2, 8'(8'h20 + i));
         checkSec("t4_sec", 4 * i + 3, 8'(8'h80 + i));
      end

      $display("[TB] test 5: address wrap");
      setAllOff();
      setSprite(8'hFC, 8'd20, 8'hA1, 8'hA2, 8'hA3);
      setSprite(8'h00, 8'd22, 8'hB1, 8'hB2, 8'hB3);
      applyStimulus(9'd25, 1'b0, 8'hFC, lat);
      checkOutput("t5_latency", lat, 32'd170);
      checkOutput("t5_count", {28'd0, sprite_count}, 32'd2);
      checkOutput("t5_s0", {31'd0, sprite0_hit}, 32'd1);
      checkOutput("t5_ovf", {31'd0, overflow}, 32'd0);
      checkSec("t5_sec", 0, 8'd20);
      checkSec("t5_sec", 1, 8'hA1);
      checkSec("t5_sec", 3, 8'hA3);
      checkSec("t5_sec", 4, 8'd22);
      checkSec("t5_sec", 5, 8'hB1);
      checkSec("t5_sec", 7, 8'hB3);
      checkSec("t5_sec", 8, 8'hFF);

      $display("[TB] test 6: reset during COPY");
      setAllOff();
      setSprite(0, 8'd5, 8'h12, 8'h01, 8'h40);
      @(negedge clk);
      scanline = 9'd12; sprite_16 = 1'b0; base_addr = 8'h00; start = 1'b1;
      repeat (36) begin
         @(negedge clk);
         start = 1'b0;
      end
      checkOutput("t6_busy_pre", {31'd0, busy}, 32'd1);
      checkOutput("t6_s0_pre", {31'd0, sprite0_hit}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("t6_busy", {31'd0, busy}, 32'd0);
      checkOutput("t6_count", {28'd0, sprite_count}, 32'd0);
      checkOutput("t6_s0", {31'd0, sprite0_hit}, 32'd0);
      checkOutput("t6_addr", {24'd0, bus.spram_addr}, 32'd0);
      applyStimulus(9'd12, 1'b0, 8'h00, lat);
      checkOutput("t6_latency", lat, 32'd166);
      checkOutput("t6_count_rerun", {28'd0, sprite_count}, 32'd1);
      checkOutput("t6_s0_rerun", {31'd0, sprite0_hit}, 32'd1);
      checkSec("t6_sec", 0, 8'h05);
      checkSec("t6_sec", 3, 8'h40);
      checkSec("t6_sec", 4, 8'hFF);

      $display("[TB] test 7: start while busy, start alongside done");
      @(negedge clk);
      scanline = 9'd12; sprite_16 = 1'b0; base_addr = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      scanline = 9'd13; sprite_16 = 1'b1; base_addr = 8'h40; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDone(lat);
      checkOutput("t7_latency", lat, 32'd159);
      checkOutput("t7_count", {28'd0, sprite_count}, 32'd1);
      scanline = 9'd13; sprite_16 = 1'b1; base_addr = 8'h00; start = 1'b1;
      waitDone(lat);
      checkOutput("t7_b2b_latency", lat, 32'd166);
      checkOutput("t7_b2b_count", {28'd0, sprite_count}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
